comparator_tree_scheduler: RTL and testbench
============================================

# comparator_tree_scheduler

Flow-control sequencer for the 5-input, 3-stage min/max comparator tree (3-bit operands). It accepts operand vectors over a valid/ready handshake and drives the tree's single global advance (`cmp_start`). It skews operand 4 so it arrives at the final stage with its own vector, and tracks per-stage validity so results leave through a valid/ready port. It sits between the fuzzy-rule operand source and the tree instance.

## Interface
- `WIDTH`, 3: operand/result width.
- `CNT_W`, 16: perf counter width (used only with the perf macro).

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous drop of all in-flight vectors.
- `in_valid`  in  1  operand vector valid.
- `in_ready`  out  1  vector accepted when `in_valid && in_ready`.
- `in_data_0`..`in_data_4`  in  WIDTH each  operand vector.
- `cmp_start`  out  1  advance strobe to the tree.
- `cmp_inputs_0`..`cmp_inputs_4`  out  WIDTH each  operands to the tree.
- `cmp_result`  in  WIDTH  tree final-stage register.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  result (= `cmp_result`).
- `busy`  out  1  any stage valid.
- `perf_accept_cnt`, `perf_stall_cnt`  out  CNT_W each  perf counters.

## Operation
- Stage valid bits `v[0..2]` track tree stage 1 (pair regs), stage 2 (merge reg) and stage 3 (result reg).
- `stall = v[2] && !out_ready`.
- `cmp_start = !flush && !stall && (in_valid || v[0] || v[1] || v[2])`. When nothing is pending, the tree is not clocked.
- `in_ready = !flush && !stall`. This is combinational from `out_ready`; the path is intentional.
- Operand routing:
  - `cmp_inputs_0..3 = in_data_0..3` (pass-through).
  - `cmp_inputs_4 = s4b`.
- On each `cmp_start`:
  - `v[0] <= accept`, `v[1] <= v[0]`, `v[2] <= v[1]`.
  - `s4a <= in_data_4` when accepting, else hold.
  - `s4b <= s4a`.
  - Net effect: operand 4 of a vector reaches the tree on the third start after acceptance, the same edge its stage-2 result enters stage 3.
- Bubbles: a `cmp_start` with `in_valid=0` inserts `v[0]=0`, so the pipeline drains without new input.
- `out_valid = v[2]`, `out_data = cmp_result`. The tree's registers are unreset; `out_data` is meaningful only while `out_valid`.
- `busy = |v`.
- `flush` (synchronous): next edge clears `v` and `s4a`/`s4b`. During the flush cycle `in_ready=0` and `cmp_start=0`. An `out_valid && out_ready` transfer in that cycle still completes.

## Timing
- Reset values: `v=0`, `s4a=s4b=0`, `out_valid=0`, `busy=0`, `cmp_start=0` (no `in_valid`), `in_ready=1`, perf counters 0.
- Latency: a vector accepted at edge t produces `out_valid=1` in the cycle after edge t+2, given no stall. Minimum is 3 cycles.
- Throughput: one vector per cycle with `out_ready=1`.
- Stall: while `stall`, the tree holds all stages, `s4a`/`s4b` hold, and `out_data` stays stable.
- Simultaneous output consume and input accept in the same cycle is legal (full throughput).
- Reset mid-operation: all in-flight vectors are lost, and no `out_valid` is produced for them.

## Configuration
- `COMPARATOR_SCHED_PERF_EN` defined:
  - `perf_accept_cnt` increments on every accept.
  - `perf_stall_cnt` increments on every cycle with `stall`.
  - Both saturate at all-ones and clear only on reset.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Test plan
All scenarios bench the tree configured for max.

- Single vector: after reset, vector {1,5,2,7,3} → `out_valid` 3 cycles after accept, `out_data=7`, then `busy=0`.
- Operand-4 skew: back-to-back {0,0,0,0,6}, {7,0,0,0,1}, {1,1,1,1,0} with `out_ready=1` → results 6, 7, 1 on three consecutive cycles.
- Backpressure: 4 back-to-back vectors, `out_ready=0` for 5 cycles once the first result appears:
  - `in_ready=0` and `out_data` frozen throughout;
  - on release, results appear in order with none lost or duplicated;
  - with the macro, `perf_stall_cnt=5`.
- Flush: 2 vectors in flight, assert `flush` for 1 cycle → `busy=0` next cycle, no `out_valid`. A new vector {2,2,2,2,4} then returns 4.
- Async reset: assert `reset_n=0` mid-stream between edges → `out_valid`/`busy` drop immediately and `in_ready=1` after release.
- Perf: with the macro, 10 accepted vectors give `perf_accept_cnt=10`. Without it, the counters read 0.

Source files
------------

// File: rtl/comparator_tree_scheduler.sv
// Valid/ready flow-control sequencer for a 5-input, 3-stage min/max comparator tree.
// Optional perf counters are built when COMPARATOR_SCHED_PERF_EN is defined.
module comparator_tree_scheduler #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data_0,
  input  logic [WIDTH-1:0] in_data_1,
  input  logic [WIDTH-1:0] in_data_2,
  input  logic [WIDTH-1:0] in_data_3,
  input  logic [WIDTH-1:0] in_data_4,
  output logic             cmp_start,
  output logic [WIDTH-1:0] cmp_inputs_0,
  output logic [WIDTH-1:0] cmp_inputs_1,
  output logic [WIDTH-1:0] cmp_inputs_2,
  output logic [WIDTH-1:0] cmp_inputs_3,
  output logic [WIDTH-1:0] cmp_inputs_4,
  input  logic [WIDTH-1:0] cmp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] perf_accept_cnt,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  localparam int unsigned NSTG = 3;

  logic [NSTG-1:0]  v_q, v_d;
  logic [WIDTH-1:0] s4a_q, s4a_d;
  logic [WIDTH-1:0] s4b_q, s4b_d;
  logic             stall;
  logic             accept;

  // Handshake, tree advance and next-state of the stage-valid / operand-4 skew pipe
  always_comb begin
    stall     = v_q[NSTG-1] && !out_ready;
    in_ready  = !flush && !stall;
    cmp_start = in_ready && (in_valid || (|v_q));
    accept    = in_valid && in_ready;
    v_d       = v_q;
    s4a_d     = s4a_q;
    s4b_d     = s4b_q;
    if (flush) begin
      v_d   = '0;
      s4a_d = '0;
      s4b_d = '0;
    end else if (cmp_start) begin
      v_d   = {v_q[NSTG-2:0], accept};
      s4b_d = s4a_q;
      if (accept) begin
        s4a_d = in_data_4;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= '0;
      s4a_q <= '0;
      s4b_q <= '0;
    end else begin
      v_q   <= v_d;
      s4a_q <= s4a_d;
      s4b_q <= s4b_d;
    end
  end

  assign cmp_inputs_0 = in_data_0;
  assign cmp_inputs_1 = in_data_1;
  assign cmp_inputs_2 = in_data_2;
  assign cmp_inputs_3 = in_data_3;
  assign cmp_inputs_4 = s4b_q;
  assign out_valid    = v_q[NSTG-1];
  assign out_data     = cmp_result;
  assign busy         = |v_q;

`ifdef COMPARATOR_SCHED_PERF_EN
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] stl_cnt_q, stl_cnt_d;

  // Saturating event counters, cleared only by reset
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    stl_cnt_d = stl_cnt_q;
    if (accept && !(&acc_cnt_q)) begin
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end
    if (stall && !(&stl_cnt_q)) begin
      stl_cnt_d = stl_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      stl_cnt_q <= stl_cnt_d;
    end
  end

  assign perf_accept_cnt = acc_cnt_q;
  assign perf_stall_cnt  = stl_cnt_q;
`else
  assign perf_accept_cnt = '0;
  assign perf_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_comparator_tree_scheduler.sv
// Bench for comparator_tree_scheduler: max-configured tree model, vector table,
// directed corner sequences and a randomized run scored against a max-of-five queue.
module tb_comparator_tree_scheduler;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned CNT_W = 16;
`ifdef COMPARATOR_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [4:0][WIDTH-1:0] d;
    logic [WIDTH-1:0]      exp;
  } vec_t;

  logic clock, reset_n, flush, in_valid, in_ready, cmp_start, out_valid, out_ready, busy;
  logic [WIDTH-1:0] in_data_0, in_data_1, in_data_2, in_data_3, in_data_4;
  logic [WIDTH-1:0] cmp_inputs_0, cmp_inputs_1, cmp_inputs_2, cmp_inputs_3, cmp_inputs_4;
  logic [WIDTH-1:0] cmp_result, out_data;
  logic [CNT_W-1:0] perf_accept_cnt, perf_stall_cnt;

  int errors = 0;
  int checks = 0;
  int n_acc  = 0;
  int n_stall = 0;
  logic [WIDTH-1:0] exp_q[$];
  vec_t tbl[8];

  comparator_tree_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_0(in_data_0), .in_data_1(in_data_1), .in_data_2(in_data_2),
    .in_data_3(in_data_3), .in_data_4(in_data_4),
    .cmp_start(cmp_start),
    .cmp_inputs_0(cmp_inputs_0), .cmp_inputs_1(cmp_inputs_1), .cmp_inputs_2(cmp_inputs_2),
    .cmp_inputs_3(cmp_inputs_3), .cmp_inputs_4(cmp_inputs_4),
    .cmp_result(cmp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .perf_accept_cnt(perf_accept_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] mx(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // External comparator tree (max), advanced only by cmp_start, unreset
  logic [WIDTH-1:0] t_p0, t_p1, t_m, t_r;
  always @(posedge clock) begin
    if (cmp_start) begin
      t_p0 <= mx(cmp_inputs_0, cmp_inputs_1);
      t_p1 <= mx(cmp_inputs_2, cmp_inputs_3);
      t_m  <= mx(t_p0, t_p1);
      t_r  <= mx(t_m, cmp_inputs_4);
    end
  end
  assign cmp_result = t_r;

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int a4, input int e);
    vec_t v;
    v.d[0] = WIDTH'(a0); v.d[1] = WIDTH'(a1); v.d[2] = WIDTH'(a2);
    v.d[3] = WIDTH'(a3); v.d[4] = WIDTH'(a4); v.exp = WIDTH'(e);
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] max5();
    logic [WIDTH-1:0] m;
    m = mx(mx(in_data_0, in_data_1), mx(in_data_2, in_data_3));
    return mx(m, in_data_4);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input vec_t v);
    in_data_0 = v.d[0]; in_data_1 = v.d[1]; in_data_2 = v.d[2];
    in_data_3 = v.d[3]; in_data_4 = v.d[4];
  endtask

  // One clock: score handshakes mid-cycle, then return just after the rising edge
  task automatic tick();
    logic [WIDTH-1:0] e;
    @(negedge clock);
    if (out_valid && !out_ready) n_stall++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_spurious: got out_data=%0d expected no result", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", int'(out_data), int'(e));
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(max5());
      n_acc++;
    end
    if (flush) exp_q.delete();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, int'(busy), 0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic run_single(input vec_t v);
    set_vec(v);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("single_in_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("single_lat1_valid", int'(out_valid), 0);
    chk("single_lat1_busy", int'(busy), 1);
    tick();
    chk("single_lat2_valid", int'(out_valid), 0);
    tick();
    chk("single_lat3_valid", int'(out_valid), 1);
    chk("single_lat3_data", int'(out_data), int'(v.exp));
    tick();
    chk("single_idle_busy", int'(busy), 0);
    chk("single_idle_valid", int'(out_valid), 0);
  endtask

  initial begin
    tbl[0] = mk(1, 5, 2, 7, 3, 7);
    tbl[1] = mk(0, 0, 0, 0, 6, 6);
    tbl[2] = mk(7, 0, 0, 0, 1, 7);
    tbl[3] = mk(1, 1, 1, 1, 0, 1);
    tbl[4] = mk(2, 2, 2, 2, 4, 4);
    tbl[5] = mk(0, 0, 0, 0, 0, 0);
    tbl[6] = mk(3, 6, 1, 0, 2, 6);
    tbl[7] = mk(0, 0, 0, 0, 7, 7);

    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_vec(tbl[5]);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmp_start", int'(cmp_start), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_perf_acc", int'(perf_accept_cnt), 0);
    chk("rst_perf_stall", int'(perf_stall_cnt), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Isolated vectors: latency, result and return to idle
    for (int i = 0; i < 8; i++) run_single(tbl[i]);

    // Operand-4 skew with back-to-back vectors
    for (int i = 1; i < 4; i++) begin
      set_vec(tbl[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("skew_r0_valid", int'(out_valid), 1);
    chk("skew_r0", int'(out_data), 6);
    tick();
    chk("skew_r1", int'(out_data), 7);
    tick();
    chk("skew_r2", int'(out_data), 1);
    tick();
    chk("skew_done_valid", int'(out_valid), 0);

    // Backpressure: first result held for five stalled cycles
    for (int i = 0; i < 3; i++) begin
      set_vec(tbl[i]);
      in_valid = 1'b1;
      tick();
    end
    set_vec(tbl[3]);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_cmp_start", int'(cmp_start), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_frozen", int'(out_data), 7);
      tick();
    end
    chk("bp_perf_stall", int'(perf_stall_cnt), PERF ? 5 : 0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_r1", int'(out_data), 6);
    drain("bp");

    // Flush with two vectors in flight
    for (int i = 6; i < 8; i++) begin
      set_vec(tbl[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", int'(in_ready), 0);
    chk("flush_cmp_start", int'(cmp_start), 0);
    tick();
    flush = 1'b0;
    chk("flush_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_valid", int'(out_valid), 0);
      tick();
    end
    run_single(tbl[4]);

    // Asynchronous reset between edges with results in flight
    for (int i = 0; i < 3; i++) begin
      set_vec(tbl[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("arst_pre_valid", int'(out_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    exp_q.delete();
    n_acc = 0;
    n_stall = 0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_perf_acc", int'(perf_accept_cnt), 0);
    chk("arst_perf_stall", int'(perf_stall_cnt), 0);
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("arst_no_valid", int'(out_valid), 0);
      tick();
    end

    // Ten accepted vectors for the accept counter
    for (int i = 0; i < 10; i++) begin
      set_vec(tbl[i % 8]);
      in_valid = 1'b1;
      tick();
    end
    drain("perf");
    chk("perf_acc10", int'(perf_accept_cnt), PERF ? 10 : 0);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data_0 = WIDTH'($urandom_range(0, 7));
      in_data_1 = WIDTH'($urandom_range(0, 7));
      in_data_2 = WIDTH'($urandom_range(0, 7));
      in_data_3 = WIDTH'($urandom_range(0, 7));
      in_data_4 = WIDTH'($urandom_range(0, 7));
      tick();
    end
    flush = 1'b0;
    drain("rand");
    chk("rand_perf_acc", int'(perf_accept_cnt), PERF ? n_acc : 0);
    chk("rand_perf_stall", int'(perf_stall_cnt), PERF ? n_stall : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
